_64b66b_rx: RTL and testbench

Self-synchronising 64b/66b descrambler for the receive path, polynomial G(x) = 1 + x^39 + x^58. It is the exact inverse of the transmit scrambler.
- Sits after the block aligner and sync-header strip.
- Descrambles LEN payload bits per valid beat.
- Registers the result with one cycle of latency.
- Tracks how many post-reset or post-resync bits have fed the tap history, and flags when the output is trustworthy (lock_o).

---
 rtl/_64b66b_rx.sv | 85 ++++++++
 tb/tb__64b66b_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/_64b66b_rx.sv
// Receive-side self-synchronising descrambler for 64b/66b, G(x) = 1 + x^39 + x^58.
// Takes LEN scrambled payload bits per valid beat (bit 0 earliest on the wire).
// Produces the descrambled word one cycle later, together with a lock flag.
// The lock flag rises once all 58 history taps come from bits received since
// the last reset or resync.
module _64b66b_rx #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           valid_i,
  input  logic [LEN-1:0] data_i,
  input  logic           resync_i,
  output logic           valid_o,
  output logic [LEN-1:0] data_o,
  output logic           lock_o
);

  localparam int         HIST  = 58;
  localparam logic [7:0] LEN_W = 8'(LEN);
  localparam logic [7:0] FULL  = 8'(HIST);

  // s_q[0] is the most recently received scrambled bit, s_q[57] the oldest
  logic [HIST-1:0] s_q;
  logic [HIST-1:0] s_next;
  logic [5:0]      cnt_q;
  logic [5:0]      base;
  logic [7:0]      sum;
  logic [5:0]      cnt_next;
  logic [LEN-1:0]  d;

  // Descramble: each output bit XORs the received bit with the received bits
  // 39 and 58 positions earlier, taken from this beat or from the history.
  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_desc
      if (gi <= 38) begin : g_hist_both
        assign d[gi] = data_i[gi] ^ s_q[38-gi] ^ s_q[57-gi];
      end else if (gi <= 57) begin : g_hist_old
        assign d[gi] = data_i[gi] ^ data_i[gi-39] ^ s_q[57-gi];
      end else begin : g_in_beat
        assign d[gi] = data_i[gi] ^ data_i[gi-39] ^ data_i[gi-58];
      end
    end
  endgenerate

  // Next history: the newest LEN bits land at the bottom in reverse order,
  // and the older history shifts up by LEN.
  generate
    for (gi = 0; gi < HIST; gi++) begin : g_shift
      if (gi < LEN) begin : g_from_beat
        assign s_next[gi] = data_i[LEN-1-gi];
      end else begin : g_from_hist
        assign s_next[gi] = s_q[gi-LEN];
      end
    end
  endgenerate

  // A coincident resync makes this beat the first bits of a fresh prime
  assign base     = resync_i ? 6'd0 : cnt_q;
  assign sum      = {2'b00, base} + LEN_W;
  assign cnt_next = (sum >= FULL) ? 6'd58 : sum[5:0];

  // History, prime counter and registered outputs
  always_ff @(posedge clk) begin
    if (!nreset) begin
      s_q     <= '1;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      lock_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        s_q    <= s_next;
        cnt_q  <= cnt_next;
        data_o <= d;
        lock_o <= (base >= 6'd58);
      end else if (resync_i) begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb__64b66b_rx.sv
// Directed bench for the 64b/66b descrambler: three instances (LEN = 32, 64, 8)
// fed by a bit-serial transmit scrambler model, plus a hand-computed vector.
module tb__64b66b_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic        valid;
  logic        resync;
  logic [31:0] din32, dout32;
  logic [63:0] din64, dout64;
  logic [7:0]  din8, dout8;
  logic        vo32, vo64, vo8;
  logic        lk32, lk64, lk8;

  int total = 0;
  int bad   = 0;

  _64b66b_rx #(.LEN(32)) dut32 (
    .clk(clk), .nreset(nreset), .valid_i(valid), .data_i(din32), .resync_i(resync),
    .valid_o(vo32), .data_o(dout32), .lock_o(lk32)
  );
  _64b66b_rx #(.LEN(64)) dut64 (
    .clk(clk), .nreset(nreset), .valid_i(valid), .data_i(din64), .resync_i(resync),
    .valid_o(vo64), .data_o(dout64), .lock_o(lk64)
  );
  _64b66b_rx #(.LEN(8)) dut8 (
    .clk(clk), .nreset(nreset), .valid_i(valid), .data_i(din8), .resync_i(resync),
    .valid_o(vo8), .data_o(dout8), .lock_o(lk8)
  );

  // Per-instance model state: 0 -> LEN 32, 1 -> LEN 64, 2 -> LEN 8
  int          lens [3] = '{32, 64, 8};
  logic [57:0] tx_hist [3];
  int          cnt [3];
  logic [63:0] plain [3];
  logic [63:0] last_out [3];
  logic        known [3];
  logic        last_lock [3];
  logic        synced [3];
  int          beat_no;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int len);
    logic [63:0] one;
    one = 64'd1;
    return (len >= 64) ? '1 : ((one << len) - 64'd1);
  endfunction

  function automatic logic [63:0] get_dout(input int id);
    case (id)
      0:       return {32'b0, dout32};
      1:       return dout64;
      default: return {56'b0, dout8};
    endcase
  endfunction

  function automatic logic get_vo(input int id);
    case (id)
      0:       return vo32;
      1:       return vo64;
      default: return vo8;
    endcase
  endfunction

  function automatic logic get_lk(input int id);
    case (id)
      0:       return lk32;
      1:       return lk64;
      default: return lk8;
    endcase
  endfunction

  task automatic set_din(input int id, input logic [63:0] v);
    case (id)
      0:       din32 = v[31:0];
      1:       din64 = v;
      default: din8  = v[7:0];
    endcase
  endtask

  // Transmit scrambler: out[n] = in[n] ^ out[n-39] ^ out[n-58], history starts all ones
  task automatic tx_scr(input int id, input logic [63:0] p, output logic [63:0] s);
    logic [57:0] h;
    logic        b;
    h = tx_hist[id];
    s = '0;
    for (int i = 0; i < lens[id]; i++) begin
      b    = p[i] ^ h[38] ^ h[57];
      s[i] = b;
      h    = {h[56:0], b};
    end
    tx_hist[id] = h;
  endtask

  // One clock of stimulus and the checks on the word it produces
  task automatic beat(input logic v, input logic r);
    logic [63:0] s;
    int          base;
    logic        exp_lock;
    @(negedge clk);
    nreset = 1'b1;
    valid  = v;
    resync = r;
    for (int id = 0; id < 3; id++) begin
      if (v) begin
        plain[id] = {$urandom, $urandom} & mask(lens[id]);
        tx_scr(id, plain[id], s);
        set_din(id, s);
      end else begin
        set_din(id, {$urandom, $urandom});
      end
    end
    @(posedge clk);
    #1;
    beat_no++;
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("valid_o[%0d]", lens[id]), 64'(get_vo(id)), 64'(v));
      if (v) begin
        base     = r ? 0 : cnt[id];
        exp_lock = (base >= 58);
        cnt[id]  = (base + lens[id] >= 58) ? 58 : base + lens[id];
        chk($sformatf("lock[%0d]", lens[id]), 64'(get_lk(id)), 64'(exp_lock));
        last_lock[id] = exp_lock;
        if (synced[id] || exp_lock) begin
          chk($sformatf("data[%0d]", lens[id]), get_dout(id), plain[id]);
          last_out[id] = plain[id];
          known[id]    = 1'b1;
        end else begin
          known[id] = 1'b0;
        end
      end else begin
        if (r) cnt[id] = 0;
        chk($sformatf("lock_hold[%0d]", lens[id]), 64'(get_lk(id)), 64'(last_lock[id]));
        if (known[id])
          chk($sformatf("data_hold[%0d]", lens[id]), get_dout(id), last_out[id]);
      end
    end
    $display("beat %0d v=%0b r=%0b lock=%0b%0b%0b d32=%h d64=%h d8=%h",
             beat_no, v, r, lk32, lk64, lk8, dout32, dout64, dout8);
  endtask

  // RX reset with a live beat on the inputs; joint also restarts the TX model
  task automatic rx_reset(input logic joint);
    @(negedge clk);
    nreset = 1'b0;
    valid  = 1'b1;
    resync = 1'b0;
    for (int id = 0; id < 3; id++) set_din(id, {$urandom, $urandom});
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("rst_valid[%0d]", lens[id]), 64'(get_vo(id)), 64'd0);
      chk($sformatf("rst_data[%0d]", lens[id]), get_dout(id), 64'd0);
      chk($sformatf("rst_lock[%0d]", lens[id]), 64'(get_lk(id)), 64'd0);
      cnt[id]       = 0;
      last_out[id]  = '0;
      known[id]     = 1'b1;
      last_lock[id] = 1'b0;
      synced[id]    = joint;
      if (joint) tx_hist[id] = '1;
    end
    beat_no = 0;
    $display("reset joint=%0b", joint);
  endtask

  logic [31:0] kv_data [3] = '{32'h0000_0000, 32'h03FF_FF80, 32'h0000_0000};
  logic        kv_lock [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    nreset = 1'b0;
    valid  = 1'b0;
    resync = 1'b0;
    din32  = '0;
    din64  = '0;
    din8   = '0;
    beat_no = 0;
    repeat (2) @(posedge clk);

    // Known vector: all-zero scrambled input from reset
    rx_reset(1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      nreset = 1'b1;
      valid  = 1'b1;
      resync = 1'b0;
      din32  = '0;
      din64  = '0;
      din8   = '0;
      chk("kv_valid_lag_pre", 64'(vo32), 64'(n != 0));
      @(posedge clk);
      #1;
      chk("kv_valid", 64'(vo32), 64'd1);
      chk("kv_data", 64'(dout32), 64'(kv_data[n]));
      chk("kv_lock", 64'(lk32), 64'(kv_lock[n]));
      $display("known beat %0d d32=%h lock=%0b", n + 1, dout32, lk32);
    end
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("kv_valid_fall", 64'(vo32), 64'd0);

    // Loopback from a joint reset, with hand-derived lock onsets
    rx_reset(1'b1);
    for (int n = 1; n <= 2000; n++) begin
      beat(1'b1, 1'b0);
      if (n <= 10) begin
        chk("lock32_hand", 64'(lk32), 64'(n >= 3));
        chk("lock64_hand", 64'(lk64), 64'(n >= 2));
        chk("lock8_hand", 64'(lk8), 64'(n >= 9));
      end
    end

    // RX-only reset while TX keeps running
    rx_reset(1'b0);
    for (int n = 1; n <= 20; n++) begin
      beat(1'b1, 1'b0);
      if (n <= 3) chk("rxrst_lock32_hand", 64'(lk32), 64'(n >= 3));
    end

    // Random valid gaps
    for (int n = 0; n < 400; n++) beat(1'($urandom_range(0, 1)), 1'b0);

    // Resync alone, then resync coincident with a beat
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    chk("resync_alone_b1", 64'(lk32), 64'd0);
    beat(1'b1, 1'b0);
    chk("resync_alone_b2", 64'(lk32), 64'd0);
    beat(1'b1, 1'b0);
    chk("resync_alone_b3", 64'(lk32), 64'd1);
    beat(1'b1, 1'b1);
    chk("resync_coinc_b1", 64'(lk32), 64'd0);
    beat(1'b1, 1'b0);
    chk("resync_coinc_b2", 64'(lk32), 64'd0);
    beat(1'b1, 1'b0);
    chk("resync_coinc_b3", 64'(lk32), 64'd1);
    for (int n = 0; n < 30; n++) beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
